// File: rtl/mio_clknrst_gen_pkg.sv
// mio_clknrst_gen_pkg: shared types, defaults and helpers for the multi-channel clock/reset generator.
`default_nettype none

package mio_clknrst_gen_pkg;

  localparam int CFG_DIV_W = 8;
  localparam int CFG_RST_W = 8;
  localparam int DEF_DIV   = 5;
  localparam int DEF_RST   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESET    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_RST_W-1:0] rst;
  } ch_cfg_t;

  // A zero half-period or hold count would stall the counters, so both floor at one.
  function automatic ch_cfg_t clamp_min1(input ch_cfg_t c);
    ch_cfg_t r;
    r.div = (c.div == '0) ? CFG_DIV_W'(1) : c.div;
    r.rst = (c.rst == '0) ? CFG_RST_W'(1) : c.rst;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mio_clknrst_gen_ch.sv
// mio_clknrst_gen_ch: one output channel -- divided clock, paired resets and the IDLE/RESET/RUN/STOPPING FSM.
`default_nettype none

module mio_clknrst_gen_ch
  import mio_clknrst_gen_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  ch_cfg_t cfg_i,
  input  logic    start_i,
  input  logic    stop_i,
  output logic    idle_o,
  output logic    ch_clk_o,
  output logic    ch_reset_o,
  output logic    ch_reset_n_o,
  output logic    ch_running_o
);

  ch_state_e            state_q;
  ch_cfg_t              work_q;
  logic [CFG_DIV_W-1:0] hc_q;
  logic [CFG_RST_W-1:0] rc_q;
  logic                 clk_q;
  logic                 rst_q;
  logic                 rst_n_q;
  logic                 run_q;
  logic                 hc_last;

  assign hc_last = (hc_q == (work_q.div - CFG_DIV_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      hc_q    <= '0;
      rc_q    <= '0;
      clk_q   <= 1'b0;
      rst_q   <= 1'b1;
      rst_n_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= RESET;
            work_q  <= clamp_min1(cfg_i);
            hc_q    <= '0;
            rc_q    <= '0;
          end
        end
        RESET, RUN: begin
          if (stop_i) begin
            rst_q   <= 1'b1;
            rst_n_q <= 1'b0;
            run_q   <= 1'b0;
            // Low clock, or a falling toggle due now: park low at once; otherwise finish the high phase.
            if (!clk_q || hc_last) begin
              clk_q   <= 1'b0;
              hc_q    <= '0;
              state_q <= IDLE;
            end else begin
              hc_q    <= hc_q + CFG_DIV_W'(1);
              state_q <= STOPPING;
            end
          end else if (hc_last) begin
            hc_q  <= '0;
            clk_q <= ~clk_q;
            if (!clk_q) begin
              if (state_q == RESET) rc_q <= rc_q + CFG_RST_W'(1);
            end else if (state_q == RESET && rc_q >= work_q.rst) begin
              state_q <= RUN;
              rst_q   <= 1'b0;
              rst_n_q <= 1'b1;
              run_q   <= 1'b1;
            end
          end else begin
            hc_q <= hc_q + CFG_DIV_W'(1);
          end
        end
        STOPPING: begin
          if (hc_last) begin
            hc_q    <= '0;
            clk_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            hc_q <= hc_q + CFG_DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle_o       = (state_q == IDLE);
  assign ch_clk_o     = clk_q;
  assign ch_reset_o   = rst_q;
  assign ch_reset_n_o = rst_n_q;
  assign ch_running_o = run_q;

endmodule

`default_nettype wire

// File: rtl/mio_clknrst_gen.sv
// mio_clknrst_gen: multi-channel clock/reset generator top -- config register file, ready mux, channel array.
`default_nettype none

module mio_clknrst_gen
  import mio_clknrst_gen_pkg::ch_cfg_t;
  import mio_clknrst_gen_pkg::CFG_DIV_W;
  import mio_clknrst_gen_pkg::CFG_RST_W;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DIV_W   = 8,
  parameter  int RST_W   = 8,
  parameter  int DEF_DIV = mio_clknrst_gen_pkg::DEF_DIV,
  parameter  int DEF_RST = mio_clknrst_gen_pkg::DEF_RST,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [RST_W-1:0]  cfg_rst,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] ch_clk,
  output logic [NUM_CH-1:0] ch_reset,
  output logic [NUM_CH-1:0] ch_reset_n,
  output logic [NUM_CH-1:0] ch_running
);

  logic [NUM_CH-1:0] idle;

  // Out-of-range channel numbers read as ready so such writes drain harmlessly.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = idle[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_cfg_t cfg_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cfg_q.div <= CFG_DIV_W'(DEF_DIV);
        cfg_q.rst <= CFG_RST_W'(DEF_RST);
      end else if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(g))) begin
        cfg_q.div <= CFG_DIV_W'(cfg_div);
        cfg_q.rst <= CFG_RST_W'(cfg_rst);
      end
    end

    mio_clknrst_gen_ch u_ch (
      .clk          (clk),
      .reset        (reset),
      .cfg_i        (cfg_q),
      .start_i      (start[g]),
      .stop_i       (stop[g]),
      .idle_o       (idle[g]),
      .ch_clk_o     (ch_clk[g]),
      .ch_reset_o   (ch_reset[g]),
      .ch_reset_n_o (ch_reset_n[g]),
      .ch_running_o (ch_running[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_mio_clknrst_gen.sv
// tb_mio_clknrst_gen: directed bench for mio_clknrst_gen with hand-computed expected timing.
`default_nettype none

module tb_mio_clknrst_gen;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch    = 2'd0;
  logic [7:0] cfg_div   = 8'd0;
  logic [7:0] cfg_rst   = 8'd0;
  logic [3:0] start     = 4'h0;
  logic [3:0] stop      = 4'h0;
  logic       cfg_ready;
  logic [3:0] ch_clk;
  logic [3:0] ch_reset;
  logic [3:0] ch_reset_n;
  logic [3:0] ch_running;

  int checks = 0;
  int errors = 0;

  mio_clknrst_gen dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_rst    (cfg_rst),
    .start      (start),
    .stop       (stop),
    .ch_clk     (ch_clk),
    .ch_reset   (ch_reset),
    .ch_reset_n (ch_reset_n),
    .ch_running (ch_running)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] rs);
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_rst   = rs;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    step(1);
    start = 4'h0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_clk", ch_clk, 4'h0);
    chk("rst_reset", ch_reset, 4'hF);
    chk("rst_reset_n", ch_reset_n, 4'h0);
    chk("rst_running", ch_running, 4'h0);
    chk("rst_ready", cfg_ready, 1'b1);
    step(1);
    reset = 1'b0;
    step(2);
    chk("idle_clk", ch_clk, 4'h0);
    chk("idle_reset", ch_reset, 4'hF);

    // Defaults on ch0: half 5, hold 4
    pulse_start(4'b0001);
    chk("d_t0_clk", ch_clk[0], 1'b0);
    step(4);
    chk("d_t4_clk", ch_clk[0], 1'b0);
    step(1);
    chk("d_t5_clk", ch_clk[0], 1'b1);
    chk("d_t5_reset", ch_reset[0], 1'b1);
    step(5);
    chk("d_t10_clk", ch_clk[0], 1'b0);
    step(29);
    chk("d_t39_clk", ch_clk[0], 1'b1);
    chk("d_t39_reset", ch_reset[0], 1'b1);
    chk("d_t39_running", ch_running[0], 1'b0);
    step(1);
    chk("d_t40_clk", ch_clk[0], 1'b0);
    chk("d_t40_reset", ch_reset[0], 1'b0);
    chk("d_t40_reset_n", ch_reset_n[0], 1'b1);
    chk("d_t40_running", ch_running[0], 1'b1);

    // Configured ch1: half 2, hold 3
    cfg_ch = 2'd1;
    #1;
    chk("c_ready_idle", cfg_ready, 1'b1);
    step(0);
    cfg_write(2'd1, 8'd2, 8'd3);
    pulse_start(4'b0010);
    chk("c_t0_clk", ch_clk[1], 1'b0);
    step(2);
    chk("c_t2_clk", ch_clk[1], 1'b1);
    step(2);
    chk("c_t4_clk", ch_clk[1], 1'b0);
    step(2);
    chk("c_t6_clk", ch_clk[1], 1'b1);
    step(5);
    chk("c_t11_clk", ch_clk[1], 1'b1);
    chk("c_t11_reset", ch_reset[1], 1'b1);
    step(1);
    chk("c_t12_clk", ch_clk[1], 1'b0);
    chk("c_t12_reset", ch_reset[1], 1'b0);
    chk("c_t12_running", ch_running[1], 1'b1);

    // Write to running ch1 stalls until it is stopped
    cfg_ch    = 2'd1;
    cfg_div   = 8'd7;
    cfg_rst   = 8'd3;
    cfg_valid = 1'b1;
    stop      = 4'b0010;
    #1;
    chk("c_ready_run", cfg_ready, 1'b0);
    step(1);
    stop = 4'h0;
    chk("c_stop_reset", ch_reset[1], 1'b1);
    chk("c_stop_running", ch_running[1], 1'b0);
    chk("c_stop_clk", ch_clk[1], 1'b0);
    chk("c_ready_after", cfg_ready, 1'b1);
    step(1);
    cfg_valid = 1'b0;
    step(6);
    chk("c_idle_clk", ch_clk[1], 1'b0);

    // Glitch-free stop on ch0 with half 3, hold 1
    stop = 4'b0001;
    step(1);
    stop = 4'h0;
    step(8);
    chk("g_park_clk", ch_clk[0], 1'b0);
    chk("g_park_reset", ch_reset[0], 1'b1);
    cfg_write(2'd0, 8'd3, 8'd1);
    pulse_start(4'b0001);
    step(2);
    chk("g_t2_clk", ch_clk[0], 1'b0);
    step(1);
    chk("g_t3_clk", ch_clk[0], 1'b1);
    step(3);
    chk("g_t6_clk", ch_clk[0], 1'b0);
    chk("g_t6_reset", ch_reset[0], 1'b0);
    step(9);
    chk("g_t15_clk", ch_clk[0], 1'b1);
    stop = 4'b0001;
    step(1);
    stop = 4'h0;
    chk("g_t16_reset", ch_reset[0], 1'b1);
    chk("g_t16_running", ch_running[0], 1'b0);
    chk("g_t16_clk", ch_clk[0], 1'b1);
    step(1);
    chk("g_t17_clk", ch_clk[0], 1'b1);
    step(1);
    chk("g_t18_clk", ch_clk[0], 1'b0);
    step(7);
    chk("g_t25_clk", ch_clk[0], 1'b0);
    cfg_ch = 2'd0;
    #1;
    chk("g_ready_idle", cfg_ready, 1'b1);

    // Clamps on ch2: div 0, rst 0
    step(0);
    cfg_write(2'd2, 8'd0, 8'd0);
    pulse_start(4'b0100);
    chk("k_t0_clk", ch_clk[2], 1'b0);
    step(1);
    chk("k_t1_clk", ch_clk[2], 1'b1);
    chk("k_t1_reset", ch_reset[2], 1'b1);
    step(1);
    chk("k_t2_clk", ch_clk[2], 1'b0);
    chk("k_t2_reset", ch_reset[2], 1'b0);
    chk("k_t2_running", ch_running[2], 1'b1);
    step(1);
    chk("k_t3_clk", ch_clk[2], 1'b1);

    // Start on a running channel is ignored
    pulse_start(4'b0100);
    chk("x_run_clk", ch_clk[2], 1'b0);
    chk("x_run_reset", ch_reset[2], 1'b0);
    chk("x_run_running", ch_running[2], 1'b1);
    step(1);
    chk("x_run_clk2", ch_clk[2], 1'b1);

    // Start and stop together on idle ch3
    start = 4'b1000;
    stop  = 4'b1000;
    step(1);
    start = 4'h0;
    stop  = 4'h0;
    step(10);
    chk("x_idle_clk", ch_clk[3], 1'b0);
    chk("x_idle_reset", ch_reset[3], 1'b1);
    chk("x_idle_running", ch_running[3], 1'b0);
    cfg_ch = 2'd3;
    #1;
    chk("x_idle_ready", cfg_ready, 1'b1);

    // All running, then asynchronous reset mid-cycle
    step(0);
    pulse_start(4'b1011);
    step(50);
    chk("a_running", ch_running, 4'hF);
    chk("a_reset", ch_reset, 4'h0);
    chk("a_reset_n", ch_reset_n, 4'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("a_async_clk", ch_clk, 4'h0);
    chk("a_async_reset", ch_reset, 4'hF);
    chk("a_async_reset_n", ch_reset_n, 4'h0);
    chk("a_async_running", ch_running, 4'h0);
    #2;
    reset = 1'b0;
    step(1);
    // ch1 was left configured with half 7; defaults must be back (half 5)
    pulse_start(4'b0010);
    step(2);
    chk("a_def_t2_clk", ch_clk[1], 1'b0);
    step(3);
    chk("a_def_t5_clk", ch_clk[1], 1'b1);
    step(5);
    chk("a_def_t10_clk", ch_clk[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
